// File: rtl/alu_pipe.sv
// Registered execute-stage integer ALU with a valid/ready output channel and RV64 word ops.
// Define ALU_MUL_EN to add the iterative radix-2 multiplier (MUL/MULH/MULHSU/MULHU).
module alu_pipe #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int TAG_WIDTH      = 5,
  parameter int SHAMT_W        = $clog2(BUS_DATA_WIDTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [5:0]                alu_control,
  input  logic [BUS_DATA_WIDTH-1:0] dataA,
  input  logic [BUS_DATA_WIDTH-1:0] dataB,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BUS_DATA_WIDTH-1:0] dataOut,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic                      illegal_op
);
  localparam int W     = BUS_DATA_WIDTH;
  localparam bit HAS_W = (W > 32);

  logic               accept, outFire;
  logic [W-1:0]       aluRes;
  logic               aluIll, isMul;
  logic [SHAMT_W-1:0] shamt;
  logic [4:0]         shamtW;
  logic [31:0]        a32, b32;
  logic signed [31:0] wRes;

  assign shamt  = dataB[SHAMT_W-1:0];
  assign shamtW = dataB[4:0];
  assign a32    = dataA[31:0];
  assign b32    = dataB[31:0];

  // Word ops: 32-bit result, sign-extended to full width by the signed size cast below.
  always_comb begin
    wRes = '0;
    case (alu_control)
      6'b010110: wRes = $signed(a32 + b32);
      6'b010111: wRes = $signed(a32 - b32);
      6'b011000: wRes = $signed(a32 << shamtW);
      6'b011001: wRes = $signed(a32 >> shamtW);
      6'b011010: wRes = $signed(a32) >>> shamtW;
      default:   wRes = '0;
    endcase
  end

  always_comb begin
    aluRes = '0;
    aluIll = 1'b0;
    isMul  = 1'b0;
    case (alu_control)
      6'b000001, 6'b001100: aluRes = dataA + dataB;
      6'b001101:            aluRes = dataA - dataB;
      6'b000010, 6'b001111: aluRes = W'($signed(dataA) < $signed(dataB));
      6'b000011, 6'b010000: aluRes = W'(dataA < dataB);
      6'b000100, 6'b010001: aluRes = dataA ^ dataB;
      6'b000101, 6'b010100: aluRes = dataA | dataB;
      6'b000110, 6'b010101: aluRes = dataA & dataB;
      6'b000111, 6'b001110: aluRes = dataA << shamt;
      6'b001000, 6'b010010: aluRes = dataA >> shamt;
      6'b001001, 6'b010011: aluRes = $signed(dataA) >>> shamt;
      6'b010110, 6'b010111, 6'b011000, 6'b011001, 6'b011010: begin
        if (HAS_W) aluRes = W'(wRes);
        else       aluIll = 1'b1;
      end
      6'b011011, 6'b011100, 6'b011101, 6'b011110: begin
`ifdef ALU_MUL_EN
        isMul  = 1'b1;
`else
        aluIll = 1'b1;
`endif
      end
      default: aluIll = 1'b1;
    endcase
  end

  assign outFire = out_valid && out_ready;
  assign accept  = in_valid && in_ready;

`ifdef ALU_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;
  state_t             state;
  logic [2*W-1:0]     prod, prodNext, prodFinal;
  logic [W-1:0]       mcand, magA, magB;
  logic [W:0]         partial;
  logic [SHAMT_W-1:0] iter;
  logic               negRes, hiRes, signA, signB;
  logic [TAG_WIDTH-1:0] mulTag;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);

  // Shift-add on magnitudes; multiplier sits in prod's low half and shifts out as the sum grows in.
  always_comb begin
    signA     = dataA[W-1] && (alu_control == 6'b011100 || alu_control == 6'b011101);
    signB     = dataB[W-1] && (alu_control == 6'b011100);
    magA      = signA ? -dataA : dataA;
    magB      = signB ? -dataB : dataB;
    partial   = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? mcand : {W{1'b0}})};
    prodNext  = {partial, prod[W-1:1]};
    prodFinal = negRes ? -prodNext : prodNext;
  end
`else
  assign in_ready = !out_valid || out_ready;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      dataOut    <= '0;
      out_tag    <= '0;
      illegal_op <= 1'b0;
`ifdef ALU_MUL_EN
      state  <= IDLE;
      prod   <= '0;
      mcand  <= '0;
      iter   <= '0;
      negRes <= 1'b0;
      hiRes  <= 1'b0;
      mulTag <= '0;
`endif
    end else begin
      if (outFire) out_valid <= 1'b0;
      if (accept && !isMul) begin
        out_valid  <= 1'b1;
        dataOut    <= aluRes;
        out_tag    <= in_tag;
        illegal_op <= aluIll;
      end
`ifdef ALU_MUL_EN
      if (accept && isMul) begin
        state  <= MUL;
        prod   <= {{W{1'b0}}, magB};
        mcand  <= magA;
        iter   <= '0;
        negRes <= signA ^ signB;
        hiRes  <= (alu_control != 6'b011011);
        mulTag <= in_tag;
      end
      if (state == MUL) begin
        prod <= prodNext;
        iter <= iter + 1'b1;
        // Final iteration writes the result directly so out_valid rises with the return to IDLE.
        if (iter == SHAMT_W'(W-1)) begin
          state      <= IDLE;
          out_valid  <= 1'b1;
          dataOut    <= hiRes ? prodFinal[2*W-1:W] : prodFinal[W-1:0];
          out_tag    <= mulTag;
          illegal_op <= 1'b0;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: vector table for single-cycle ops plus backpressure, reset and multiply sequences.
module tb_alu_pipe;
  localparam int W  = 64;
  localparam int TW = 5;
  localparam int NV = 18;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, out_valid, out_ready, illegal_op;
  logic [5:0]    alu_control;
  logic [W-1:0]  dataA, dataB, dataOut;
  logic [TW-1:0] in_tag, out_tag;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  alu_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .dataA(dataA), .dataB(dataB), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .dataOut(dataOut),
    .out_tag(out_tag), .illegal_op(illegal_op)
  );

  typedef struct {
    logic [5:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    logic         ill;
  } vec_t;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag);
    alu_control = op; dataA = a; dataB = b; in_tag = tag; in_valid = 1'b1;
  endtask

`ifdef ALU_MUL_EN
  task automatic mulOp(input string name, input logic [5:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp);
    int n;
    @(negedge clk);
    drive(op, a, b, 5'd21);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, ".busy"}, W'(in_ready), 0);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, ".lat"}, W'(n), W);
    chk({name, ".data"}, dataOut, exp);
    chk({name, ".tag"}, W'(out_tag), 21);
    chk({name, ".ill"}, W'(illegal_op), 0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] bpA [4];
    int           seen;
    bpA = '{64'd100, 64'd200, 64'd300, 64'd400};

    vecs[0]  = '{6'b000001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,  64'd0, 1'b0};
    vecs[1]  = '{6'b000010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,  64'd1, 1'b0};
    vecs[2]  = '{6'b000011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,  64'd0, 1'b0};
    vecs[3]  = '{6'b001001, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[4]  = '{6'b000111, 64'd1, 64'h40, 64'd1, 1'b0};
    vecs[5]  = '{6'b010110, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[6]  = '{6'b011010, 64'h0000_0000_8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000, 1'b0};
    vecs[7]  = '{6'b111111, 64'd5, 64'd6, 64'd0, 1'b1};
    vecs[8]  = '{6'b001101, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[9]  = '{6'b010001, 64'hF0F0, 64'h0FF0, 64'hFF00, 1'b0};
    vecs[10] = '{6'b000101, 64'hF000, 64'h000F, 64'hF00F, 1'b0};
    vecs[11] = '{6'b010101, 64'hFF00, 64'h0FF0, 64'h0F00, 1'b0};
    vecs[12] = '{6'b001000, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0};
    vecs[13] = '{6'b010111, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[14] = '{6'b011000, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[15] = '{6'b011001, 64'hFFFF_FFFF_8000_0000, 64'd31, 64'd1, 1'b0};
    vecs[16] = '{6'b001100, 64'd2, 64'd3, 64'd5, 1'b0};
`ifdef ALU_MUL_EN
    vecs[17] = '{6'b000000, 64'd3, 64'd4, 64'd0, 1'b1};
`else
    vecs[17] = '{6'b011011, 64'd3, 64'd4, 64'd0, 1'b1};
`endif

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_control = '0; dataA = '0; dataB = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", W'(out_valid), 0);
    chk("rst.data", dataOut, 0);
    chk("rst.tag", W'(out_tag), 0);
    chk("rst.ill", W'(illegal_op), 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rst.ready", W'(in_ready), 1);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b, TW'(i + 3));
      #1 chk($sformatf("vec%0d.ready", i), W'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("vec%0d.valid", i), W'(out_valid), 1);
      chk($sformatf("vec%0d.data", i), dataOut, vecs[i].exp);
      chk($sformatf("vec%0d.tag", i), W'(out_tag), W'(i + 3));
      chk($sformatf("vec%0d.ill", i), W'(illegal_op), W'(vecs[i].ill));
    end
    @(posedge clk); #1;
    chk("drain.valid", W'(out_valid), 0);

    // Backpressure: first op accepted then held; the rest wait until out_ready returns.
    @(negedge clk);
    out_ready = 1'b0;
    drive(6'b000001, bpA[0], 64'd1, 5'd10);
    @(posedge clk); #1;
    chk("bp0.valid", W'(out_valid), 1);
    chk("bp0.data", dataOut, 64'd101);
    @(negedge clk);
    drive(6'b000001, bpA[1], 64'd2, 5'd11);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bphold%0d.ready", c), W'(in_ready), 0);
      chk($sformatf("bphold%0d.data", c), dataOut, 64'd101);
      chk($sformatf("bphold%0d.tag", c), W'(out_tag), 10);
      chk($sformatf("bphold%0d.valid", c), W'(out_valid), 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("bprel.ready", W'(in_ready), 1);
    for (int k = 1; k < 4; k++) begin
      if (k > 1) begin
        @(negedge clk);
        drive(6'b000001, bpA[k], W'(k + 1), TW'(10 + k));
      end
      @(posedge clk); #1;
      chk($sformatf("bp%0d.data", k), dataOut, bpA[k] + W'(k + 1));
      chk($sformatf("bp%0d.tag", k), W'(out_tag), W'(10 + k));
      chk($sformatf("bp%0d.valid", k), W'(out_valid), 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bpend.valid", W'(out_valid), 0);

    // Reset while a result is being held.
    @(negedge clk);
    out_ready = 1'b0;
    drive(6'b000001, 64'd7, 64'd8, 5'd9);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rstheld.pre", dataOut, 64'd15);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rstheld.valid", W'(out_valid), 0);
    chk("rstheld.data", dataOut, 0);
    chk("rstheld.tag", W'(out_tag), 0);
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    #1 chk("rstheld.ready", W'(in_ready), 1);

`ifdef ALU_MUL_EN
    mulOp("mulh", 6'b011100, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    mulOp("mulhu", 6'b011110, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFE);
    mulOp("mul", 6'b011011, 64'd12345, 64'd1000, 64'd12345000);
    mulOp("mulhsu", 6'b011101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF);

    // Reset in the middle of a multiply discards it.
    @(negedge clk);
    drive(6'b011011, 64'd3, 64'd4, 5'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mulrst.valid", W'(out_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("mulrst.ready", W'(in_ready), 1);
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mulrst.noout", W'(seen), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
